seq_sam_ctrl: RTL and testbench
===============================

SEQ_SAM_CTRL -- requirements
Module: seq_sam_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits (min 2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  multiplicand, two's complement.
REQ-007 SHALL have port: b  input  WIDTH  multiplier, two's complement.
REQ-008 SHALL have port: flush  input  1  synchronous abort of the current operation.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: result  output  2*WIDTH  signed product a*b.
REQ-012 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE, encoded in the shared package.
REQ-014 SHALL drive in_ready high only in IDLE; an accept is in_valid && in_ready at a clk edge.
REQ-015 On accept, SHALL register |a|, |b| (full WIDTH-bit magnitudes, so -2^(WIDTH-1) is exact), sign = a[MSB]^b[MSB], and SHALL clear the accumulator and the step counter, then go to RUN.
REQ-016 In each RUN cycle, SHALL add (multiplicand << count) to the 2*WIDTH accumulator when the multiplier LSB is 1, shift the multiplier right by 1, and increment count.
REQ-017 SHALL leave RUN for DONE after the step with count == WIDTH-1; with no early exit, out_valid rises WIDTH+1 clk edges after the accept edge.
REQ-018 On entering DONE, SHALL register result = sign ? two's-complement negation of acc : acc, and SHALL assert out_valid.
REQ-019 SHALL hold result and out_valid stable in DONE while out_ready is low.
REQ-020 In DONE with out_ready high, SHALL deassert out_valid and go to IDLE at that edge; a new accept is possible no earlier than the following edge.
REQ-021 flush high at an edge SHALL force IDLE, drop out_valid and discard the operation; flush overrides every other event, including an accept or handshake at the same edge.
REQ-022 A product of zero SHALL yield result 0 regardless of sign (no negative zero).
REQ-023 The accumulator SHALL never overflow 2*WIDTH bits; no saturation logic is required.

Reset
REQ-024 rst_n low SHALL immediately set state=IDLE, out_valid=0, busy=0, result=0, acc=0, count=0, in_ready=1 after release; reset mid-RUN discards the operation.

Configuration
REQ-025 With SAM_EARLY_TERM_EN defined, SHALL also leave RUN for DONE after any step whose shifted multiplier is all zero (b=0 or b=1 give one RUN cycle); REQ-017 latency becomes the upper bound.
REQ-026 Without SAM_EARLY_TERM_EN, SHALL always perform exactly WIDTH RUN cycles; results SHALL be identical in both builds.

Structure
REQ-027 Package sam_pkg SHALL hold the default WIDTH constant, the FSM state typedef and the count-width function/constant.
REQ-028 The single-step shift/conditional-add datapath SHALL be a sub-module sam_acc_step; the FSM, handshake and sign logic stay in seq_sam_ctrl.

Verification
REQ-029 a=3, b=5, out_ready=1, macro off -> result=15, out_valid exactly 33 edges after accept.
REQ-030 a=-7, b=6 -> result=0xFFFFFFFF_FFFFFFD6 (-42); a=0x80000000, b=0x80000000 -> result=0x40000000_00000000.
REQ-031 a=-1, b=-1, out_ready held low 5 cycles in DONE -> result=1 stable and out_valid high throughout; in_ready low until the cycle after the handshake.
REQ-032 SAM_EARLY_TERM_EN defined, a=123, b=1 -> result=123, out_valid 2 edges after accept; b=0 -> result=0, same latency.
REQ-033 flush asserted at RUN step 10, and separately rst_n pulsed at RUN step 10 -> IDLE, out_valid=0, no result; next operation 2*3 -> 6 correct.

Source files
------------

// File: rtl/sam_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: default width,
// FSM state encoding and the step-counter width helper.
package sam_pkg;

  localparam int SAM_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sam_state_e;

  // Counter must hold 0..width-1; never narrower than one bit.
  function automatic int sam_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int SAM_CNT_W = sam_cnt_width(SAM_WIDTH);

endpackage

// File: rtl/sam_if.sv
// Operand/result handshake bundle for seq_sam_ctrl; master drives operands and
// consumes results, slave is the multiplier.
interface sam_if import sam_pkg::*; #(
  parameter int WIDTH = SAM_WIDTH
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/sam_acc_step.sv
// One shift-and-add step: conditionally accumulates the multiplicand shifted by
// the step index and shifts the multiplier right by one.
module sam_acc_step import sam_pkg::*; #(
  parameter int WIDTH = SAM_WIDTH,
  parameter int CNT_W = sam_cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [CNT_W-1:0]   count,
  output logic [2*WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0]   mplier_out
);

  logic [2*WIDTH-1:0] addend;

  always_comb begin
    addend     = {{WIDTH{1'b0}}, mcand} << count;
    acc_out    = mplier[0] ? (acc_in + addend) : acc_in;
    mplier_out = mplier >> 1;
  end

endmodule

// File: rtl/seq_sam_ctrl.sv
// Sequential signed multiplier: magnitudes are multiplied by shift-and-add, sign
// applied at the end. Optional macro SAM_EARLY_TERM_EN stops once the multiplier is exhausted.
module seq_sam_ctrl import sam_pkg::*; #(
  parameter int WIDTH = SAM_WIDTH
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  sam_if.slave  bus
);

  localparam int               CNT_W    = sam_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sam_state_e         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sign_q, sign_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   step_mplier;
  logic               last_step;

  // Unsigned WIDTH-bit magnitudes keep the most negative operand exact.
  assign a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;

  sam_acc_step #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step (
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc_in     (acc_q),
    .count      (count_q),
    .acc_out    (step_acc),
    .mplier_out (step_mplier)
  );

`ifdef SAM_EARLY_TERM_EN
  assign last_step = (count_q == LAST_CNT) || (step_mplier == '0);
`else
  assign last_step = (count_q == LAST_CNT);
`endif

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    result_d    = result_q;
    count_d     = count_q;
    sign_d      = sign_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          mcand_d    = a_mag;
          mplier_d   = b_mag;
          sign_d     = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          acc_d      = '0;
          count_d    = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d    = step_acc;
        mplier_d = step_mplier;
        count_d  = count_q + CNT_W'(1);
        if (last_step) begin
          state_d = DONE;
        end
      end
      // First DONE cycle applies the sign, so the negator never follows the adder.
      DONE: begin
        if (!out_valid_q) begin
          result_d    = sign_q ? -acc_q : acc_q;
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      count_q     <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      count_q     <= count_d;
      sign_q      <= sign_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_sam_ctrl.sv
// Bench for seq_sam_ctrl: a transaction-level model (signed product, cycle
// countdown) checked every cycle, plus directed vectors with literal expectations.
module tb_seq_sam_ctrl;

`ifdef SAM_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic flush;
  int   total;
  int   passed;
  bit   cmp_en;

  sam_if #(.WIDTH(32)) bus ();

  seq_sam_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input int full, input int early);
    return EARLY ? early : full;
  endfunction

  // Edges from accept to out_valid: one per multiplier step plus the sign cycle.
  function automatic int model_latency(input logic [31:0] bv);
    logic [31:0] mag;
    int steps;
    mag = bv[31] ? -bv : bv;
    steps = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) steps = i + 1;
    if (!EARLY) steps = 32;
    return steps + 1;
  endfunction

  bit          m_ir, m_ov, m_busy;
  logic [63:0] m_res;
  longint      m_prod;
  int          m_rem;

  always @(posedge clk or negedge rst_n) begin
    longint sa, sb;
    if (!rst_n) begin
      m_ir = 1'b1; m_ov = 1'b0; m_busy = 1'b0; m_res = '0; m_rem = 0;
    end else if (flush) begin
      m_ir = 1'b1; m_ov = 1'b0; m_busy = 1'b0; m_rem = 0;
    end else if (m_ir && bus.in_valid) begin
      sa = longint'($signed(bus.a));
      sb = longint'($signed(bus.b));
      m_prod = sa * sb;
      m_ir = 1'b0; m_busy = 1'b1;
      m_rem = model_latency(bus.b);
    end else if (m_busy && !m_ov) begin
      m_rem--;
      if (m_rem == 0) begin
        m_ov = 1'b1;
        m_res = m_prod;
      end
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0; m_busy = 1'b0; m_ir = 1'b1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      check("cmp_in_ready", bus.in_ready, m_ir);
      check("cmp_out_valid", bus.out_valid, m_ov);
      check("cmp_busy", bus.busy, m_busy);
      check("cmp_result", bus.result, m_res);
    end
  end

  task automatic apply_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp_res, input int exp_lat);
    int edges;
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (!bus.out_valid && edges < 200);
    check({name, "_latency"}, 64'(edges), 64'(exp_lat));
    check({name, "_result"}, bus.result, exp_res);
    @(posedge clk);
    #1;
  endtask

  task automatic start_long_op();
    @(negedge clk);
    bus.a = 32'd100; bus.b = 32'h7000_0001; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int edges;
    total = 0; passed = 0; cmp_en = 1'b0;
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_result", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    apply_op("3x5", 32'd3, 32'd5, 64'd15, pick(33, 4));
    apply_op("m7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, pick(33, 4));
    apply_op("min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
    apply_op("max_x_min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 33);
    apply_op("123x1", 32'd123, 32'd1, 64'd123, pick(33, 2));
    apply_op("5x0", 32'd5, 32'd0, 64'd0, pick(33, 2));
    apply_op("0xm5", 32'd0, 32'hFFFF_FFFB, 64'd0, pick(33, 4));

    // Result held under back-pressure
    @(negedge clk);
    bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (!bus.out_valid && edges < 200);
    check("hold_latency", 64'(edges), 64'(pick(33, 2)));
    repeat (5) begin
      @(posedge clk);
      #1;
      check("hold_result", bus.result, 64'd1);
      check("hold_out_valid", bus.out_valid, 1'b1);
      check("hold_in_ready", bus.in_ready, 1'b0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_out_valid", bus.out_valid, 1'b0);
    check("hs_in_ready", bus.in_ready, 1'b1);

    // Flush mid-RUN
    start_long_op();
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_busy", bus.busy, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    repeat (40) @(posedge clk);
    apply_op("2x3_after_flush", 32'd2, 32'd3, 64'd6, pick(33, 3));

    // Asynchronous reset mid-RUN
    start_long_op();
    rst_n = 1'b0;
    #2;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_result", bus.result, 64'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    apply_op("2x3_after_reset", 32'd2, 32'd3, 64'd6, pick(33, 3));

    // Flush wins over an accept at the same edge
    @(negedge clk);
    bus.a = 32'd9; bus.b = 32'd9; bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_accept_busy", bus.busy, 1'b0);
    check("flush_accept_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0; flush = 1'b0;
    repeat (40) @(posedge clk);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
